// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-channel definitions: write-size codes, default bus widths
// and the arbiter state encoding.
package mem_if_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] WS_BYTE = 2'd0;
  localparam logic [1:0] WS_HALF = 2'd1;
  localparam logic [1:0] WS_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of N requester channels plus the single shared memory port.
// slave = arbiter side, master = requesters/memory environment side.
interface mem_port_arbiter_if
  import mem_if_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);
  logic [N_PORTS*ADDR_W-1:0] p_addr;
  logic [N_PORTS*DATA_W-1:0] p_wdata;
  logic [N_PORTS*2-1:0]      p_ws;
  logic [N_PORTS-1:0]        p_req;
  logic [N_PORTS-1:0]        p_wr;
  logic [N_PORTS*DATA_W-1:0] p_rdata;
  logic [N_PORTS-1:0]        p_rdy;

  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [1:0]                mem_ws;
  logic                      mem_req;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_rdy;

  modport slave (
    input  p_addr, p_wdata, p_ws, p_req, p_wr, mem_rdata, mem_rdy,
    output p_rdata, p_rdy, mem_addr, mem_wdata, mem_ws, mem_req, mem_wr
  );

  modport master (
    output p_addr, p_wdata, p_ws, p_req, p_wr, mem_rdata, mem_rdy,
    input  p_rdata, p_rdy, mem_addr, mem_wdata, mem_ws, mem_req, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner selection: round-robin starting after `last`, or
// fixed priority with port 0 highest.
module rr_pick #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic               rr_mode_i,
  output logic [N_PORTS-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               valid_o
);

  int unsigned start;
  int unsigned idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = 32'd0;
    start     = rr_mode_i ? ((32'(last_i) + 32'd1) % N_PORTS) : 32'd0;
    // Upward search with wrap; first hit wins.
    for (int unsigned off = 0; off < N_PORTS; off++) begin
      idx = (start + off) % N_PORTS;
      if (!valid_o && req_i[IDX_W'(idx)]) begin
        valid_o                = 1'b1;
        gnt_oh_o[IDX_W'(idx)]  = 1'b1;
        gnt_idx_o              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges N cache request channels onto one memory port, one transaction
// at a time, with registered mem_* and p_* outputs.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          gnt_q, gnt_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
  logic [1:0]                mem_ws_q, mem_ws_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_wr_q, mem_wr_d;
  logic [N_PORTS-1:0]        p_rdy_q, p_rdy_d;
  logic [N_PORTS*DATA_W-1:0] p_rdata_q, p_rdata_d;

  logic [N_PORTS-1:0]        pick_oh;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i     (bus.p_req),
    .last_i    (last_q),
    .rr_mode_i (RR_MODE != 0),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ws_d    = mem_ws_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    p_rdy_d     = '0;
    p_rdata_d   = p_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d   = ST_ISSUE;
          gnt_d     = pick_idx;
          mem_req_d = 1'b1;
          for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (pick_oh[i]) begin
              mem_addr_d  = bus.p_addr[i*ADDR_W +: ADDR_W];
              mem_wdata_d = bus.p_wdata[i*DATA_W +: DATA_W];
              mem_ws_d    = bus.p_ws[i*2 +: 2];
              mem_wr_d    = bus.p_wr[i];
            end
          end
        end
      end
      ST_ISSUE: begin
        if (bus.mem_rdy) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          last_d    = gnt_q;
          for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (gnt_q == IDX_W'(i)) begin
              p_rdy_d[i]                     = 1'b1;
              p_rdata_d[i*DATA_W +: DATA_W]  = bus.mem_rdata;
            end
          end
        end
      end
      // Extra cycle so the served requester can drop req before re-arbitration.
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      last_q      <= IDX_W'(N_PORTS - 1);
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ws_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      p_rdy_q     <= '0;
      p_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ws_q    <= mem_ws_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      p_rdy_q     <= p_rdy_d;
      p_rdata_q   <= p_rdata_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_ws    = mem_ws_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.p_rdy     = p_rdy_q;
  assign bus.p_rdata   = p_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a round-robin instance and a fixed-priority instance,
// each with a simple latency-programmable memory model.
module tb_mem_port_arbiter;
  import mem_if_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef logic [1:0] pidx_t;
  typedef struct {
    pidx_t         port;
    logic [DW-1:0] data;
    bit            chk_data;
    int            exp_cyc;
    int            gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  mem_port_arbiter_if #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  mem_port_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut_rr (
    .clock (clk), .reset (rst_n), .bus (ifa.slave));
  mem_port_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_fp (
    .clock (clk), .reset (rst_n), .bus (ifb.slave));

  logic [NP-1:0][AW-1:0] a_addr, b_addr;
  logic [NP-1:0][DW-1:0] a_wdata, b_wdata;
  logic [NP-1:0][1:0]    a_ws, b_ws;
  logic [NP-1:0]         a_req, b_req, a_wr, b_wr;

  assign ifa.p_addr = a_addr;  assign ifb.p_addr = b_addr;
  assign ifa.p_wdata = a_wdata; assign ifb.p_wdata = b_wdata;
  assign ifa.p_ws = a_ws;      assign ifb.p_ws = b_ws;
  assign ifa.p_req = a_req;    assign ifb.p_req = b_req;
  assign ifa.p_wr = a_wr;      assign ifb.p_wr = b_wr;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_a = 1, lat_b = 1, kick_a = -1;
  int cnt_a = 0, cnt_b = 0;
  int last_rdy_a = -1000, last_rdy_b = -1000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic push(input bit on_b, input pidx_t p, input logic [DW-1:0] d,
                      input bit cd, input int ec, input int gap);
    exp_t it;
    it.port = p; it.data = d; it.chk_data = cd; it.exp_cyc = ec; it.gap = gap;
    if (on_b) sb_b.push_back(it); else sb_a.push_back(it);
  endtask

  task automatic score(input string tag, input exp_t it, input logic [NP-1:0] rdy,
                       input logic [NP-1:0][DW-1:0] rd, input int last, input int now);
    chk({tag, "_rdy_port"}, 128'(rdy), 128'(NP'(1) << it.port));
    if (it.chk_data) chk({tag, "_rdata"}, 128'(rd[it.port]), 128'(it.data));
    if (it.exp_cyc >= 0) chk({tag, "_rdy_cycle"}, 128'(now), 128'(it.exp_cyc));
    if (it.gap > 0) chk({tag, "_rdy_spacing"}, 128'(now - last), 128'(it.gap));
  endtask

  // Monitor: pops one expectation per p_rdy pulse.
  initial begin : monitor
    exp_t it;
    forever begin
      @(negedge clk);
      if (ifa.p_rdy != '0) begin
        if (sb_a.size() == 0)
          fail("rr_unexpected_rdy", $sformatf("p_rdy=%b with nothing pending", ifa.p_rdy));
        else begin
          it = sb_a.pop_front();
          score("rr", it, ifa.p_rdy, ifa.p_rdata, last_rdy_a, cyc);
        end
        last_rdy_a = cyc;
      end
      if (ifb.p_rdy != '0) begin
        if (sb_b.size() == 0)
          fail("fp_unexpected_rdy", $sformatf("p_rdy=%b with nothing pending", ifb.p_rdy));
        else begin
          it = sb_b.pop_front();
          score("fp", it, ifb.p_rdy, ifb.p_rdata, last_rdy_b, cyc);
        end
        last_rdy_b = cyc;
      end
    end
  end

  initial begin : mem_model_a
    ifa.mem_rdy = 1'b0;
    ifa.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ifa.mem_rdy = 1'b0; cnt_a = 0;
      end else if (ifa.mem_rdy) ifa.mem_rdy = 1'b0;
      else if (cyc == kick_a) begin
        ifa.mem_rdy = 1'b1; ifa.mem_rdata = 32'hBAD0_0BAD;
      end else if (ifa.mem_req) begin
        cnt_a++;
        if (cnt_a >= lat_a) begin
          ifa.mem_rdy = 1'b1; ifa.mem_rdata = mem_val(ifa.mem_addr); cnt_a = 0;
        end
      end
    end
  end

  initial begin : mem_model_b
    ifb.mem_rdy = 1'b0;
    ifb.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ifb.mem_rdy = 1'b0; cnt_b = 0;
      end else if (ifb.mem_rdy) ifb.mem_rdy = 1'b0;
      else if (ifb.mem_req) begin
        cnt_b++;
        if (cnt_b >= lat_b) begin
          ifb.mem_rdy = 1'b1; ifb.mem_rdata = mem_val(ifb.mem_addr); cnt_b = 0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic wait_drop(input bit on_b, input pidx_t p, input bit drop);
    logic [NP-1:0] r;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      r = on_b ? ifb.p_rdy : ifa.p_rdy;
      if (r[p]) begin
        if (drop) begin
          if (on_b) b_req[p] = 1'b0; else a_req[p] = 1'b0;
        end
        return;
      end
    end
    fail("wait_rdy_timeout", $sformatf("no p_rdy[%0d] within 100 cycles", p));
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_mem_req"},   128'(ifa.mem_req),   '0);
    chk({tag, "_mem_wr"},    128'(ifa.mem_wr),    '0);
    chk({tag, "_mem_addr"},  128'(ifa.mem_addr),  '0);
    chk({tag, "_mem_wdata"}, 128'(ifa.mem_wdata), '0);
    chk({tag, "_mem_ws"},    128'(ifa.mem_ws),    '0);
    chk({tag, "_p_rdy"},     128'(ifa.p_rdy),     '0);
    chk({tag, "_p_rdata"},   128'(ifa.p_rdata),   '0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    a_addr = '0; a_wdata = '0; a_ws = '0; a_req = '0; a_wr = '0;
    b_addr = '0; b_wdata = '0; b_ws = '0; b_req = '0; b_wr = '0;
    do_reset();
    chk_a_zero("reset");
    chk("reset_fp_mem_req", 128'(ifb.mem_req), '0);
    chk("reset_fp_p_rdy",   128'(ifb.p_rdy),   '0);

    // Single read on port 1, memory answers in cycle 3.
    lat_a = 3; c = cyc;
    a_addr[1] = 32'h100; a_req[1] = 1'b1;
    push(0, 2'd1, 32'hDEAD_BEEF, 1, c + 4, 0);
    next_cycle();
    chk("read_mem_req",  128'(ifa.mem_req),  128'(1'b1));
    chk("read_mem_addr", 128'(ifa.mem_addr), 128'(32'h100));
    chk("read_mem_wr",   128'(ifa.mem_wr),   '0);
    wait_drop(0, 2'd1, 1);

    // Round-robin with all four ports requesting, 1-cycle memory.
    do_reset();
    lat_a = 1; c = cyc;
    a_addr[0] = 32'h1000; a_addr[1] = 32'h1004; a_addr[2] = 32'h1008; a_addr[3] = 32'h100C;
    push(0, 2'd0, 32'h1000_EFFF, 1, c + 2, 0);
    push(0, 2'd1, 32'h1004_EFFB, 1, -1, 3);
    push(0, 2'd2, 32'h1008_EFF7, 1, -1, 3);
    push(0, 2'd3, 32'h100C_EFF3, 1, -1, 3);
    push(0, 2'd0, 32'h1000_EFFF, 1, -1, 3);
    a_req = '1;
    wait_drop(0, 2'd0, 0);
    wait_drop(0, 2'd1, 0);
    wait_drop(0, 2'd2, 0);
    wait_drop(0, 2'd3, 0);
    wait_drop(0, 2'd0, 0);
    a_req = '0;

    // Word write on port 0 with a 5-cycle memory stall; inputs change mid-ISSUE.
    next_cycle();
    lat_a = 5; c = cyc;
    a_addr[0] = 32'h2000; a_wdata[0] = 32'h1234_5678; a_ws[0] = WS_WORD; a_wr[0] = 1'b1;
    a_req[0] = 1'b1;
    push(0, 2'd0, '0, 0, c + 6, 0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      chk("wr_mem_req",   128'(ifa.mem_req),   128'(1'b1));
      chk("wr_mem_addr",  128'(ifa.mem_addr),  128'(32'h2000));
      chk("wr_mem_wdata", 128'(ifa.mem_wdata), 128'(32'h1234_5678));
      chk("wr_mem_ws",    128'(ifa.mem_ws),    128'(WS_WORD));
      chk("wr_mem_wr",    128'(ifa.mem_wr),    128'(1'b1));
      a_addr[0] = 32'hFFFF_0000; a_wdata[0] = '1; a_ws[0] = WS_BYTE;
    end
    next_cycle();
    chk("wr_mem_req_fall", 128'(ifa.mem_req), '0);
    wait_drop(0, 2'd0, 1);
    a_wr[0] = 1'b0;

    // Port 1 drops req on the edge of its rdy; no second grant may follow.
    next_cycle();
    lat_a = 2; c = cyc;
    a_addr[1] = 32'h6004; a_req[1] = 1'b1;
    push(0, 2'd1, 32'h6004_9FFB, 1, c + 3, 0);
    wait_drop(0, 2'd1, 1);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      chk("noregrant_mem_req", 128'(ifa.mem_req), '0);
    end

    // Asynchronous reset while a read is in flight.
    lat_a = 20;
    a_addr[2] = 32'h4000; a_req[2] = 1'b1;
    repeat (3) next_cycle();
    chk("rst_pre_mem_req", 128'(ifa.mem_req), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1 chk_a_zero("async_rst");
    a_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    kick_a = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk("stray_rdy_mem_req", 128'(ifa.mem_req), '0);
    end
    lat_a = 1; c = cyc;
    a_addr[0] = 32'h5000; a_addr[3] = 32'h500C;
    push(0, 2'd0, 32'h5000_AFFF, 1, c + 2, 0);
    push(0, 2'd3, 32'h500C_AFF3, 1, -1, 3);
    a_req[0] = 1'b1; a_req[3] = 1'b1;
    wait_drop(0, 2'd0, 1);
    wait_drop(0, 2'd3, 1);

    // Fixed priority: port 0 keeps winning until it releases req.
    next_cycle();
    lat_b = 1; c = cyc;
    b_addr[0] = 32'h3000; b_addr[2] = 32'h3008;
    push(1, 2'd0, 32'h3000_CFFF, 1, c + 2, 0);
    push(1, 2'd0, 32'h3000_CFFF, 1, -1, 3);
    push(1, 2'd0, 32'h3000_CFFF, 1, -1, 3);
    push(1, 2'd2, 32'h3008_CFF7, 1, -1, 3);
    b_req[0] = 1'b1; b_req[2] = 1'b1;
    wait_drop(1, 2'd0, 0);
    wait_drop(1, 2'd0, 0);
    wait_drop(1, 2'd0, 1);
    wait_drop(1, 2'd2, 1);

    repeat (6) next_cycle();
    chk("rr_scoreboard_drained", 128'(sb_a.size()), '0);
    chk("fp_scoreboard_drained", 128'(sb_b.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
